fp8_add_sequencer: RTL and testbench
====================================

Name: fp8_add_sequencer

Overview:
- Upstream feeder and result collector for the single-shot E4M3 adder.
- Buffers a byte stream of E4M3 operands in a small FIFO and pairs consecutive words as (a, b).
- For each pair: holds a/b stable on the adder inputs, pulses the adder's active-high clear for one cycle, waits a fixed settle window covering the adder's EXP step plus worst-case NORM steps, then captures the adder output.
- Presents each captured result on a valid/ready output port.

Parameters:
- FIFO_DEPTH, 4: input FIFO entries; power of two, at least 2.
- SETTLE_CYCLES, 5: cycles from clear deassertion to result capture (1 EXP + 4 NORM); at least 1.
- CNT_W, 8: width of the completed-pair counter.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; the block is in reset while reset=0.
- in_valid  input  1  input word valid.
- in_ready  output  1  FIFO can accept a word.
- in_data  input  8  E4M3 operand.
- adder_a  output  8  operand a to adder, registered.
- adder_b  output  8  operand b to adder, registered.
- adder_clear  output  1  active-high clear to adder.
- adder_y  input  8  adder result.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- out_data  output  8  captured E4M3 sum.
- pair_count  output  CNT_W  results accepted downstream; wraps modulo 2^CNT_W.

Behaviour:
Reset:
- Asynchronous, active-low reset=0 clears the FIFO pointers and count, adder_a, adder_b, out_data, out_valid and pair_count to 0, and sets the state to IDLE.
- adder_clear = !reset | (state==CLEAR), so the adder is also held in clear during reset.
- Reset mid-operation abandons the pair in flight and any buffered words; no partial output is produced.

FIFO:
- Push when in_valid & in_ready.
- in_ready = (count != FIFO_DEPTH), taken from the registered count.
- No push while full, even if a pop occurs the same cycle.
- Pop is internal only (IDLE and FETCH_B).
- A push and a pop in the same cycle leave count unchanged; pointers wrap modulo FIFO_DEPTH.

State machine (IDLE, FETCH_B, CLEAR, SETTLE, HOLD):
- IDLE: if count >= 2, adder_a <= head, pop, go to FETCH_B. A single leftover word waits in the FIFO indefinitely. count counts words already buffered; a word pushed this cycle does not count until next cycle.
- FETCH_B: adder_b <= head, pop, go to CLEAR. count >= 1 is guaranteed here.
- CLEAR: adder_clear=1 for exactly one cycle; adder_a/adder_b already stable. Load settle counter with SETTLE_CYCLES-1, go to SETTLE.
- SETTLE: decrement the counter each cycle. At 0: out_data <= adder_y, out_valid <= 1, go to HOLD.
- HOLD: out_data stable while out_valid=1. On out_valid & out_ready: out_valid <= 0, pair_count <= pair_count+1, go to IDLE. adder_a/adder_b stay unchanged until the next IDLE pop.

Latency and throughput:
- IDLE pop at cycle t0 gives FETCH_B at t0+1, CLEAR at t0+2, and SETTLE at t0+3 through t0+2+SETTLE_CYCLES.
- out_valid rises at t0+3+SETTLE_CYCLES.
- No pipelining: one pair in flight. Throughput is one result per SETTLE_CYCLES+4 cycles with out_ready held high.

Other rules:
- Backpressure on out_ready stalls the FSM only; the FIFO keeps accepting words until full.
- No arithmetic on data; words are passed bit-exact.

Test Plan:
- Basic add: push 0x38, 0x38 (1.0+1.0), out_ready=1 -> out_data=0x40, out_valid high exactly 1 cycle at t0+8 (SETTLE_CYCLES=5), pair_count=1.
- Aligned-shift add: push 0x38, 0x40 (1.0+2.0) -> out_data=0x44; adder_clear high exactly one cycle, 2 cycles after the pop of 0x38.
- Backpressure and full: out_ready=0, push 6 words back-to-back -> first pair in HOLD, remaining 4 words buffered, in_ready=0 after the 6th push, out_data stable. Release out_ready -> 3 results in push order, pair_count=3.
- Odd word: push 3 words -> 1 result, 1 word held, no second clear. Push a 4th -> second result follows.
- Reset mid-SETTLE: drive reset=0 for 1 cycle during SETTLE -> out_valid=0, pair_count=0, in_ready=1, adder_clear=1 while reset is low, no result after release.
- pair_count wrap: CNT_W=2, 5 pairs -> pair_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/fp8_add_sequencer.sv
// Feeds operand pairs from a byte FIFO into a single-shot E4M3 adder,
// clears it, waits a fixed settle window, and returns the sum on a valid/ready port.
module fp8_add_sequencer #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 5,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic [7:0]       adder_a,
  output logic [7:0]       adder_b,
  output logic             adder_clear,
  input  logic [7:0]       adder_y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] pair_count
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, FETCH_B, CLEAR, SETTLE, HOLD} state_t;

  state_t              state;
  logic [7:0]          mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FCNT_W-1:0]   count;
  logic [SET_W-1:0]    settle_cnt;
  logic                push;
  logic                pop;
  logic                pair_ready;

  assign in_ready    = (count != FCNT_W'(FIFO_DEPTH));
  assign push        = in_valid && in_ready;
  assign pair_ready  = (count >= FCNT_W'(2));
  assign pop         = ((state == IDLE) && pair_ready) || (state == FETCH_B);
  assign adder_clear = !reset || (state == CLEAR);

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + FCNT_W'(1);
        2'b01:   count <= count - FCNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Pair sequencing: fetch a, fetch b, clear the adder, settle, hold the result.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      adder_a    <= '0;
      adder_b    <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      pair_count <= '0;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pair_ready) begin
            adder_a <= mem[rd_ptr];
            state   <= FETCH_B;
          end
        end
        FETCH_B: begin
          adder_b <= mem[rd_ptr];
          state   <= CLEAR;
        end
        CLEAR: begin
          settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
          state      <= SETTLE;
        end
        SETTLE: begin
          if (settle_cnt == '0) begin
            out_data  <= adder_y;
            out_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            settle_cnt <= settle_cnt - SET_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            pair_count <= pair_count + CNT_W'(1);
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Bench for fp8_add_sequencer: a timed E4M3 adder model plus a pair-order scoreboard.
module tb_fp8_add_sequencer;

  localparam int unsigned FIFO_DEPTH    = 4;
  localparam int unsigned SETTLE_CYCLES = 5;
  localparam int unsigned CNT_W         = 2;

  logic             clock;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [7:0]       adder_a;
  logic [7:0]       adder_b;
  logic             adder_clear;
  logic [7:0]       adder_y;
  logic             out_valid;
  logic             out_ready;
  logic [7:0]       out_data;
  logic [CNT_W-1:0] pair_count;

  fp8_add_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .SETTLE_CYCLES(SETTLE_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .adder_a(adder_a), .adder_b(adder_b), .adder_clear(adder_clear), .adder_y(adder_y),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .pair_count(pair_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;
  int exp_pc = 0;

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
    else for (int i = 0; i < -k; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real e4m3_val(input logic [7:0] c);
    int  e;
    int  m;
    real v;
    e = int'(c[6:3]);
    m = int'(c[2:0]);
    if (e == 0) v = (real'(m) / 8.0) * pow2(-6);
    else        v = (1.0 + real'(m) / 8.0) * pow2(e - 7);
    if (c[7]) v = -v;
    return v;
  endfunction

  // Nearest positive finite E4M3 code, ties to even mantissa.
  function automatic logic [7:0] e4m3_enc(input real s);
    logic [7:0] best;
    logic [7:0] cc;
    real        bd;
    real        d;
    best = 8'h00;
    bd   = 1.0e9;
    for (int c = 0; c < 127; c++) begin
      cc = 8'(c);
      d  = e4m3_val(cc) - s;
      if (d < 0.0) d = -d;
      if ((d < bd) || ((d == bd) && !cc[0] && best[0])) begin
        bd   = d;
        best = cc;
      end
    end
    return best;
  endfunction

  function automatic logic [7:0] ref_add(input logic [7:0] a, input logic [7:0] b);
    return e4m3_enc(e4m3_val(a) + e4m3_val(b));
  endfunction

  function automatic logic [7:0] rand_op();
    return 8'($urandom_range(0, 32'h6F));
  endfunction

  // Adder model: output is only correct once SETTLE_CYCLES cycles have followed a clear.
  int adder_age = 1000;
  always @(posedge clock) begin
    if (adder_clear) adder_age <= 0;
    else if (adder_age < 1000) adder_age <= adder_age + 1;
  end
  always_comb begin
    logic [7:0] s;
    s = ref_add(adder_a, adder_b);
    adder_y = (adder_age >= int'(SETTLE_CYCLES) - 1) ? s : ~s;
  end

  // Passive recorder of clears, valid cycles and accepted results.
  int         clear_q[$];
  int         rise_q[$];
  int         valid_q[$];
  logic [7:0] res_q[$];
  logic [7:0] resa_q[$];
  logic [7:0] resb_q[$];
  logic       prev_valid = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      if (adder_clear) clear_q.push_back(cyc);
      if (out_valid) valid_q.push_back(cyc);
      if (out_valid && !prev_valid) rise_q.push_back(cyc);
      if (out_valid && out_ready) begin
        res_q.push_back(out_data);
        resa_q.push_back(adder_a);
        resb_q.push_back(adder_b);
      end
      prev_valid <= out_valid;
    end else begin
      prev_valid <= 1'b0;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    clear_q.delete(); rise_q.delete(); valid_q.delete();
    res_q.delete(); resa_q.delete(); resb_q.delete();
  endtask

  task automatic push(input logic [7:0] d, output bit ok);
    in_valid = 1'b1;
    in_data  = d;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      step();
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (res_q.size() >= n) break;
      step();
    end
    ok = (res_q.size() >= n);
  endtask

  function automatic logic [7:0] res_at(input int k);
    return (k < res_q.size()) ? res_q[k] : 8'hxx;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    step(); step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    total++; if (pair_count !== '0) begin bad++; $display("FAIL reset_pair_count got %0d want 0", pair_count); end
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    total++; if (adder_clear !== 1'b1) begin bad++; $display("FAIL reset_adder_clear got %b want 1", adder_clear); end
    total++; if ({adder_a, adder_b, out_data} !== 24'h0) begin bad++; $display("FAIL reset_data got %h want 000000", {adder_a, adder_b, out_data}); end
    reset = 1'b1;
    step();
    exp_pc = 0;
    total++; if (adder_clear !== 1'b0) begin bad++; $display("FAIL idle_adder_clear got %b want 0", adder_clear); end
  endtask

  task automatic test_basic_add();
    int c0; bit ok; bit pok;
    clear_logs(); out_ready = 1'b1; c0 = cyc;
    push(8'h38, pok); push(8'h38, ok); pok &= ok;
    wait_results(1, 60, ok);
    repeat (3) step();
    exp_pc++;
    total++; if (!(ok && pok)) begin bad++; $display("FAIL basic_timeout got %0d results want 1", res_q.size()); end
    total++; if (res_at(0) !== 8'h40) begin bad++; $display("FAIL basic_sum got %h want 40", res_at(0)); end
    total++; if (rise_q.size() < 1 || rise_q[0] != c0 + 10) begin bad++; $display("FAIL basic_latency got cycle %0d want %0d", rise_q.size() ? rise_q[0] - c0 : -1, 10); end
    total++; if (valid_q.size() != 1) begin bad++; $display("FAIL basic_valid_width got %0d cycles want 1", valid_q.size()); end
    total++; if (pair_count !== CNT_W'(exp_pc)) begin bad++; $display("FAIL basic_pair_count got %0d want %0d", pair_count, exp_pc % 4); end
  endtask

  task automatic test_aligned_shift();
    int c0; bit ok; bit pok;
    clear_logs(); out_ready = 1'b1; c0 = cyc;
    push(8'h38, pok); push(8'h40, ok); pok &= ok;
    wait_results(1, 60, ok);
    repeat (3) step();
    exp_pc++;
    total++; if (res_at(0) !== 8'h44) begin bad++; $display("FAIL shift_sum got %h want 44", res_at(0)); end
    total++; if (clear_q.size() != 1) begin bad++; $display("FAIL shift_clear_width got %0d cycles want 1", clear_q.size()); end
    total++; if (clear_q.size() < 1 || clear_q[0] != c0 + 4) begin bad++; $display("FAIL shift_clear_time got %0d want %0d", clear_q.size() ? clear_q[0] - c0 : -1, 4); end
    total++; if ({adder_a, adder_b} !== 16'h3840) begin bad++; $display("FAIL shift_operands got %h want 3840", {adder_a, adder_b}); end
    total++; if (!(ok && pok)) begin bad++; $display("FAIL shift_timeout got %0d results want 1", res_q.size()); end
  endtask

  task automatic test_backpressure_full();
    logic [7:0] w[6]; logic [7:0] held; bit ok; bit pok; int waited;
    clear_logs(); out_ready = 1'b0; pok = 1'b1;
    for (int i = 0; i < 6; i++) begin w[i] = rand_op(); push(w[i], ok); pok &= ok; end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_in_ready got %b want 0", in_ready); end
    waited = 0;
    while (!out_valid && waited < 50) begin step(); waited++; end
    held = out_data;
    total++; if (held !== ref_add(w[0], w[1])) begin bad++; $display("FAIL bp_hold_data got %h want %h", held, ref_add(w[0], w[1])); end
    repeat (6) step();
    total++; if ({out_valid, out_data} !== {1'b1, held}) begin bad++; $display("FAIL bp_stable got %b/%h want 1/%h", out_valid, out_data, held); end
    total++; if (in_ready !== 1'b0 || pair_count !== CNT_W'(exp_pc)) begin bad++; $display("FAIL bp_stall got in_ready=%b pc=%0d want 0/%0d", in_ready, pair_count, exp_pc % 4); end
    out_ready = 1'b1;
    wait_results(3, 100, ok);
    step();
    exp_pc += 3;
    total++; if (!(ok && pok)) begin bad++; $display("FAIL bp_timeout got %0d results want 3", res_q.size()); end
    for (int k = 0; k < 3; k++) begin
      total++; if (res_at(k) !== ref_add(w[2*k], w[2*k+1])) begin bad++; $display("FAIL bp_result%0d got %h want %h", k, res_at(k), ref_add(w[2*k], w[2*k+1])); end
    end
    total++; if (pair_count !== CNT_W'(exp_pc)) begin bad++; $display("FAIL bp_pair_count got %0d want %0d", pair_count, exp_pc % 4); end
  endtask

  task automatic test_odd_word();
    logic [7:0] w[4]; bit ok; bit pok;
    clear_logs(); out_ready = 1'b1; pok = 1'b1;
    for (int i = 0; i < 3; i++) begin w[i] = rand_op(); push(w[i], ok); pok &= ok; end
    wait_results(1, 60, ok); pok &= ok;
    repeat (30) step();
    total++; if (res_q.size() != 1 || clear_q.size() != 1) begin bad++; $display("FAIL odd_single got results=%0d clears=%0d want 1/1", res_q.size(), clear_q.size()); end
    total++; if (res_at(0) !== ref_add(w[0], w[1])) begin bad++; $display("FAIL odd_first got %h want %h", res_at(0), ref_add(w[0], w[1])); end
    w[3] = rand_op(); push(w[3], ok); pok &= ok;
    wait_results(2, 60, ok); pok &= ok;
    step();
    exp_pc += 2;
    total++; if (res_at(1) !== ref_add(w[2], w[3])) begin bad++; $display("FAIL odd_second got %h want %h", res_at(1), ref_add(w[2], w[3])); end
    total++; if (!pok || clear_q.size() != 2) begin bad++; $display("FAIL odd_clears got %0d want 2", clear_q.size()); end
    total++; if (pair_count !== CNT_W'(exp_pc)) begin bad++; $display("FAIL odd_pair_count got %0d want %0d", pair_count, exp_pc % 4); end
  endtask

  task automatic test_reset_mid_settle();
    bit ok; int waited;
    clear_logs(); out_ready = 1'b1;
    push(rand_op(), ok); push(rand_op(), ok); push(rand_op(), ok);
    waited = 0;
    while (clear_q.size() == 0 && waited < 50) begin step(); waited++; end
    step(); step();
    reset = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || pair_count !== '0) begin bad++; $display("FAIL rst_mid_outputs got valid=%b pc=%0d want 0/0", out_valid, pair_count); end
    total++; if (in_ready !== 1'b1 || adder_clear !== 1'b1) begin bad++; $display("FAIL rst_mid_ctrl got in_ready=%b clear=%b want 1/1", in_ready, adder_clear); end
    step();
    reset = 1'b1;
    exp_pc = 0;
    step();
    clear_logs();
    push(rand_op(), ok);
    repeat (30) step();
    total++; if (res_q.size() != 0 || clear_q.size() != 0) begin bad++; $display("FAIL rst_mid_no_result got results=%0d clears=%0d want 0/0", res_q.size(), clear_q.size()); end
    total++; if (out_valid !== 1'b0 || pair_count !== '0) begin bad++; $display("FAIL rst_mid_after got valid=%b pc=%0d want 0/0", out_valid, pair_count); end
  endtask

  task automatic test_pair_count_wrap();
    int exp_seq[5]; bit ok;
    exp_seq = '{1, 2, 3, 0, 1};
    reset = 1'b0; step(); reset = 1'b1; step();
    clear_logs(); out_ready = 1'b1; exp_pc = 0;
    for (int k = 0; k < 5; k++) begin
      push(rand_op(), ok); push(rand_op(), ok);
      wait_results(k + 1, 60, ok);
      step();
      total++; if (!ok || pair_count !== CNT_W'(exp_seq[k])) begin bad++; $display("FAIL wrap_pc%0d got %0d want %0d", k, pair_count, exp_seq[k]); end
    end
    exp_pc = 5;
  endtask

  task automatic test_random();
    logic [7:0] w[16]; int idx; bit acc; bit ok;
    clear_logs();
    for (int i = 0; i < 16; i++) w[i] = rand_op();
    idx = 0;
    for (int i = 0; i < 3000 && res_q.size() < 8; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (idx < 16) && ($urandom_range(0, 3) != 0);
      in_data   = (idx < 16) ? w[idx] : 8'h00;
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    wait_results(8, 100, ok);
    step();
    exp_pc += 8;
    total++; if (!ok || idx != 16) begin bad++; $display("FAIL rand_count got results=%0d words=%0d want 8/16", res_q.size(), idx); end
    for (int k = 0; k < 8; k++) begin
      total++; if (res_at(k) !== ref_add(w[2*k], w[2*k+1])) begin bad++; $display("FAIL rand_result%0d got %h want %h", k, res_at(k), ref_add(w[2*k], w[2*k+1])); end
      total++; if (k >= resa_q.size() || {resa_q[k], resb_q[k]} !== {w[2*k], w[2*k+1]}) begin bad++; $display("FAIL rand_operands%0d got pair index mismatch want %h%h", k, w[2*k], w[2*k+1]); end
    end
    total++; if (pair_count !== CNT_W'(exp_pc)) begin bad++; $display("FAIL rand_pair_count got %0d want %0d", pair_count, exp_pc % 4); end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_aligned_shift();
    test_backpressure_full();
    test_odd_word();
    test_reset_mid_settle();
    test_pair_count_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish");
    $fatal(1);
  end

endmodule
